// File: rtl/prog_delay_line.sv
// prog_delay_line
// Runtime-programmable delay line for a WIDTH-bit word plus its valid flag.
// The delay in force (dly_cur) selects which of MAX_DELAY shift stages drives
// the output. Loading a new delay flushes the line: every stage valid bit is
// cleared, so stale words never appear at the new tap. A fill counter reports
// when the line again holds dly_cur samples.
//
// Optional feature macro: PROG_DELAY_BYPASS_EN
//   defined   : dly=0 is legal and turns the block into a combinational
//               bypass (dout=din, dout_vld=din_vld, primed=1). The stages keep
//               shifting underneath.
//   undefined : dly=0 clamps to 1, and there is no combinational path from
//               din to dout.
//
// Handshake: there is no backpressure. A word is accepted on every rising
// edge where en=1 and is tagged valid when din_vld=1. The en input stalls the
// whole line, including the fill counter. dly_ld is a single-cycle strobe. It
// is honoured whether en is high or low.
module prog_delay_line #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16,
    parameter int DEF_DELAY = 4,
    parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din_vld,
    input  logic [WIDTH-1:0] din,
    input  logic             dly_ld,
    input  logic [DLY_W-1:0] dly,
    output logic             dout_vld,
    output logic [WIDTH-1:0] dout,
    output logic             primed,
    output logic [DLY_W-1:0] dly_cur
);

    // Fill status, derived from the fill counter against the delay in force.
    typedef enum logic [1:0] {
        ST_FLUSHED = 2'd0,
        ST_FILLING = 2'd1,
        ST_PRIMED  = 2'd2
    } fill_state_t;

    localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);
    localparam logic [DLY_W-1:0] DEF_D = DLY_W'(DEF_DELAY);

    logic [WIDTH-1:0] data_q [MAX_DELAY];
    logic [MAX_DELAY-1:0] vld_q;

    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] dly_nxt;
    logic [DLY_W-1:0] dly_clamped;
    logic [DLY_W-1:0] fill_q;
    logic [DLY_W-1:0] fill_nxt;
    fill_state_t      state_q;
    fill_state_t      state_nxt;

    logic             tap_vld;
    logic [WIDTH-1:0] tap_data;

    // Clamp the requested delay into the legal range.
    always_comb begin
        dly_clamped = dly;
        if (dly > MAX_D) begin
            dly_clamped = MAX_D;
        end else if (dly == '0) begin
`ifdef PROG_DELAY_BYPASS_EN
            dly_clamped = '0;
`else
            dly_clamped = DLY_W'(1);
`endif
        end
    end

    // Next delay and next fill count. A load restarts the count at one word
    // when the load cycle also shifts. In bypass (delay 0) the count stays at
    // zero, so the line still reads as primed.
    always_comb begin
        dly_nxt  = dly_q;
        fill_nxt = fill_q;
        if (dly_ld) begin
            dly_nxt = dly_clamped;
            if (en && (dly_clamped != '0)) begin
                fill_nxt = DLY_W'(1);
            end else begin
                fill_nxt = '0;
            end
        end else if (en && (fill_q < dly_q)) begin
            fill_nxt = fill_q + DLY_W'(1);
        end
    end

    // Fill state that will hold after this edge.
    always_comb begin
        state_nxt = ST_FILLING;
        if (fill_nxt == dly_nxt) begin
            state_nxt = ST_PRIMED;
        end else if (fill_nxt == '0) begin
            state_nxt = ST_FLUSHED;
        end
    end

    // Delay register, fill counter and fill-status state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q   <= DEF_D;
            fill_q  <= '0;
            state_q <= ST_FLUSHED;
        end else begin
            dly_q   <= dly_nxt;
            fill_q  <= fill_nxt;
            state_q <= state_nxt;
        end
    end

    // Valid bits shift on en. A load clears every valid bit except the word
    // captured in the load cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (en) begin
            if (dly_ld) begin
                vld_q <= {{(MAX_DELAY-1){1'b0}}, din_vld};
            end else begin
                vld_q <= {vld_q[MAX_DELAY-2:0], din_vld};
            end
        end else if (dly_ld) begin
            vld_q <= '0;
        end
    end

    // Data stages shift on en. A flush leaves them alone because the cleared
    // valid bits mask them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                data_q[i] <= '0;
            end
        end else if (en) begin
            data_q[0] <= din;
            for (int i = 1; i < MAX_DELAY; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Output tap: select stage dly_cur-1 from registers only.
    always_comb begin
        tap_vld  = 1'b0;
        tap_data = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (dly_q == DLY_W'(i + 1)) begin
                tap_vld  = vld_q[i];
                tap_data = data_q[i];
            end
        end
    end

    // Drive outputs. In bypass mode, delay 0 routes the input straight through.
    always_comb begin
        dout_vld = tap_vld;
        dout     = tap_data;
        primed   = (state_q == ST_PRIMED);
`ifdef PROG_DELAY_BYPASS_EN
        if (dly_q == '0) begin
            dout_vld = din_vld;
            dout     = din;
            primed   = 1'b1;
        end
`endif
    end

    assign dly_cur = dly_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line
// Randomized and directed stimulus for prog_delay_line. The reference model
// keeps the list of words accepted since the last flush, newest first. The
// expected output is the entry dly_cur-1 places back in that list.
// Honours PROG_DELAY_BYPASS_EN the same way the design does.
module tb_prog_delay_line;

    localparam int WIDTH     = 8;
    localparam int MAX_DELAY = 16;
    localparam int DEF_DELAY = 4;
    localparam int DLY_W     = $clog2(MAX_DELAY + 1);

    logic             clk;
    logic             rst;
    logic             en;
    logic             din_vld;
    logic [WIDTH-1:0] din;
    logic             dly_ld;
    logic [DLY_W-1:0] dly;
    logic             dout_vld;
    logic [WIDTH-1:0] dout;
    logic             primed;
    logic [DLY_W-1:0] dly_cur;

    int n_checks;
    int n_errors;

    // Model state: words accepted since the last flush, index 0 is the newest.
    logic [WIDTH:0] hist_q[$];
    int             m_dly;

    prog_delay_line #(
        .WIDTH    (WIDTH),
        .MAX_DELAY(MAX_DELAY),
        .DEF_DELAY(DEF_DELAY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din_vld (din_vld),
        .din     (din),
        .dly_ld  (dly_ld),
        .dly     (dly),
        .dout_vld(dout_vld),
        .dout    (dout),
        .primed  (primed),
        .dly_cur (dly_cur)
    );

    // Clock generation: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_dly(input int d);
        if (d > MAX_DELAY) return MAX_DELAY;
`ifdef PROG_DELAY_BYPASS_EN
        if (d == 0) return 0;
`else
        if (d == 0) return 1;
`endif
        return d;
    endfunction

    // Compare every output against the model. dout is only meaningful while valid.
    task automatic check_outputs();
        logic             e_vld;
        logic [WIDTH-1:0] e_data;
        logic             e_primed;
        e_vld    = 1'b0;
        e_data   = '0;
        e_primed = (hist_q.size() >= m_dly);
        if (m_dly == 0) begin
            e_vld  = din_vld;
            e_data = din;
        end else if (hist_q.size() >= m_dly) begin
            e_vld  = hist_q[m_dly-1][WIDTH];
            e_data = hist_q[m_dly-1][WIDTH-1:0];
        end
        check_val("dout_vld", 32'(dout_vld), 32'(e_vld));
        if (e_vld) check_val("dout", 32'(dout), 32'(e_data));
        check_val("primed", 32'(primed), 32'(e_primed));
        check_val("dly_cur", 32'(dly_cur), 32'(m_dly));
    endtask

    // Advance the model for one rising edge that sampled the given inputs.
    task automatic model_edge(input logic e, input logic v, input logic [WIDTH-1:0] d,
                              input logic l, input logic [DLY_W-1:0] y);
        if (l) begin
            hist_q.delete();
            m_dly = clamp_dly(int'(y));
        end
        if (e) begin
            hist_q.push_front({v, d});
            if (hist_q.size() > MAX_DELAY) void'(hist_q.pop_back());
        end
    endtask

    // One clock cycle: drive after the edge, check at negedge, update the model at the edge.
    task automatic drive_cycle(input logic e, input logic v, input logic [WIDTH-1:0] d,
                               input logic l, input logic [DLY_W-1:0] y);
        en      = e;
        din_vld = v;
        din     = d;
        dly_ld  = l;
        dly     = y;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(e, v, d, l, y);
        #1;
    endtask

    // Assert reset mid-cycle and check that the outputs clear at once.
    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        check_val("rst_dout_vld", 32'(dout_vld), 32'd0);
        check_val("rst_dout", 32'(dout), 32'd0);
        check_val("rst_primed", 32'(primed), 32'd0);
        check_val("rst_dly_cur", 32'(dly_cur), 32'(DEF_DELAY));
        hist_q.delete();
        m_dly = DEF_DELAY;
        en = 1'b0; din_vld = 1'b0; din = '0; dly_ld = 1'b0; dly = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_dly    = DEF_DELAY;
        rst = 1'b0; en = 1'b0; din_vld = 1'b0; din = '0; dly_ld = 1'b0; dly = '0;
        @(posedge clk);
        #1;
        async_reset();

        // Fixed delay 4: stream 0x01..0x0A, then drain.
        for (int i = 1; i <= 10; i++) drive_cycle(1'b1, 1'b1, WIDTH'(i), 1'b0, '0);
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0);

        // Stall: delay 3, stream 0xA0..0xA5 with a two-cycle en drop mid-stream.
        drive_cycle(1'b1, 1'b0, '0, 1'b1, DLY_W'(3));
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                drive_cycle(1'b0, 1'b0, '0, 1'b0, '0);
                drive_cycle(1'b0, 1'b0, '0, 1'b0, '0);
            end
            drive_cycle(1'b1, 1'b1, WIDTH'(8'hA0 + i), 1'b0, '0);
        end
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0);

        // Reprogram while streaming: delay 4, then load 7 with en high.
        drive_cycle(1'b1, 1'b1, 8'h10, 1'b1, DLY_W'(4));
        for (int i = 1; i < 8; i++) drive_cycle(1'b1, 1'b1, WIDTH'(8'h10 + i), 1'b0, '0);
        drive_cycle(1'b1, 1'b1, 8'h55, 1'b1, DLY_W'(7));
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b1, WIDTH'(8'h60 + i), 1'b0, '0);

        // Back-to-back loads: the last one wins.
        drive_cycle(1'b1, 1'b1, 8'h71, 1'b1, DLY_W'(9));
        drive_cycle(1'b0, 1'b1, 8'h72, 1'b1, DLY_W'(2));
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, WIDTH'(8'h80 + i), 1'b0, '0);

        // Clamps: 0 and 31.
        drive_cycle(1'b1, 1'b1, 8'h90, 1'b1, '0);
`ifdef PROG_DELAY_BYPASS_EN
        check_val("clamp_zero", 32'(dly_cur), 32'd0);
`else
        check_val("clamp_zero", 32'(dly_cur), 32'd1);
`endif
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, WIDTH'(8'h91 + i), 1'b0, '0);
        drive_cycle(1'b1, 1'b1, 8'hB0, 1'b1, DLY_W'(31));
        check_val("clamp_max", 32'(dly_cur), 32'(MAX_DELAY));
        for (int i = 1; i < 20; i++) drive_cycle(1'b1, 1'b1, WIDTH'(8'hB0 + i), 1'b0, '0);

`ifdef PROG_DELAY_BYPASS_EN
        // Bypass then back to delay 2.
        drive_cycle(1'b1, 1'b1, 8'hC0, 1'b1, '0);
        for (int i = 1; i < 5; i++) drive_cycle(1'b1, 1'b1, WIDTH'(8'hC0 + i), 1'b0, '0);
        drive_cycle(1'b1, 1'b1, 8'hD0, 1'b1, DLY_W'(2));
        for (int i = 1; i < 5; i++) drive_cycle(1'b1, 1'b1, WIDTH'(8'hD0 + i), 1'b0, '0);
`endif

        // Reset in the middle of a stream.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, WIDTH'($urandom_range(0, 255)), 1'b0, '0);
        async_reset();

        // Random traffic with occasional stalls and reloads.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                        1'($urandom_range(0, 1)),
                        WIDTH'($urandom_range(0, 255)),
                        ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                        DLY_W'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
